// File: rtl/sift_seq_pkg.sv
// Shared types and constants for the SIFT stage sequencer.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
//
// Contents: sequencer state enum, error code enum, pipeline stage indices.
package sift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_ABORT   = 2'd2
  } err_code_t;

  // Stage order in the SIFT datapath; index 0 runs first.
  localparam int STAGE_GAUSS = 0;
  localparam int STAGE_DOG   = 1;
  localparam int STAGE_GRAD  = 2;
  localparam int STAGE_KEYPT = 3;
  localparam int STAGE_DESC  = 4;
  localparam int SEQ_NUM_STAGES = 5;

endpackage

// File: rtl/sift_stage_sequencer_next_enabled_stage.sv
// Priority encoder: lowest set mask bit strictly above an index (or anywhere).
// Latency: purely combinational, zero cycles.
// Backpressure: none; result is a pure function of the inputs.
//
// Ports:
//   i_mask   - per-stage enable mask
//   i_first  - when high, search the whole mask and ignore i_above
//   i_above  - only bits with index strictly greater than this are eligible
//   o_found  - an eligible enabled stage exists
//   o_idx    - index of the lowest eligible enabled stage (0 when none)
module next_enabled_stage #(
  parameter int NUM_STAGES = 5
) (
  input  logic [NUM_STAGES-1:0]         i_mask,
  input  logic                          i_first,
  input  logic [$clog2(NUM_STAGES)-1:0] i_above,
  output logic                          o_found,
  output logic [$clog2(NUM_STAGES)-1:0] o_idx
);

  localparam int IDX_W = $clog2(NUM_STAGES);

  // Walk from the top down so the lowest eligible index is written last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_first || (IDX_W'(i) > i_above))) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/sift_stage_sequencer.sv
// Sequences the SIFT stages in index order with start/done handshakes, cycle counts and a watchdog.
// Latency: one cycle from accepted start/done to the next stage_start or pipeline_done.
// Backpressure: start is ignored while busy; only stage_done[current_stage] is honoured.
//
// Ports:
//   clk, rst_in          - clock, asynchronous active-high reset
//   start                - launch pulse (accepted in IDLE/DONE/ERROR)
//   abort                - level; kills the run while waiting on a stage
//   stage_enable         - enable mask, latched on accepted start
//   stage_done           - per-stage one-cycle completion pulses
//   stage_start          - one-hot one-cycle launch pulses
//   stage_abort          - one-cycle pulse on timeout or abort
//   current_stage        - stage being waited on (holds after completion)
//   busy                 - high while a run is in progress
//   pipeline_done        - one-cycle pulse on successful completion
//   stage_cycles(_valid) - cycle count of the stage that just finished
//   error, error_code, error_stage - sticky error report, cleared on next start
module sift_stage_sequencer
  import sift_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 5,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_WIDTH      = 24
) (
  input  logic                          clk,
  input  logic                          rst_in,
  input  logic                          start,
  input  logic                          abort,
  input  logic [NUM_STAGES-1:0]         stage_enable,
  input  logic [NUM_STAGES-1:0]         stage_done,
  output logic [NUM_STAGES-1:0]         stage_start,
  output logic                          stage_abort,
  output logic [$clog2(NUM_STAGES)-1:0] current_stage,
  output logic                          busy,
  output logic                          pipeline_done,
  output logic [CNT_WIDTH-1:0]          stage_cycles,
  output logic                          stage_cycles_valid,
  output logic                          error,
  output logic [1:0]                    error_code,
  output logic [$clog2(NUM_STAGES)-1:0] error_stage
);

  localparam int IDX_W = $clog2(NUM_STAGES);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

  seq_state_t            r_state;
  logic [NUM_STAGES-1:0] r_mask;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [NUM_STAGES-1:0] r_stage_start;
  logic                  r_stage_abort;
  logic [IDX_W-1:0]      r_cur;
  logic                  r_busy;
  logic                  r_pipeline_done;
  logic [CNT_WIDTH-1:0]  r_stage_cycles;
  logic                  r_cycles_vld;
  logic                  r_error;
  err_code_t             r_err_code;
  logic [IDX_W-1:0]      r_err_stage;

  logic                  w_first_found;
  logic [IDX_W-1:0]      w_first_idx;
  logic                  w_next_found;
  logic [IDX_W-1:0]      w_next_idx;

  // First stage is searched on the live enable input so the launch needs no extra cycle.
  next_enabled_stage #(.NUM_STAGES(NUM_STAGES)) u_first (
    .i_mask  (stage_enable),
    .i_first (1'b1),
    .i_above ('0),
    .o_found (w_first_found),
    .o_idx   (w_first_idx)
  );

  next_enabled_stage #(.NUM_STAGES(NUM_STAGES)) u_next (
    .i_mask  (r_mask),
    .i_first (1'b0),
    .i_above (r_cur),
    .o_found (w_next_found),
    .o_idx   (w_next_idx)
  );

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_state         <= IDLE;
      r_mask          <= '0;
      r_cnt           <= '0;
      r_stage_start   <= '0;
      r_stage_abort   <= 1'b0;
      r_cur           <= '0;
      r_busy          <= 1'b0;
      r_pipeline_done <= 1'b0;
      r_stage_cycles  <= '0;
      r_cycles_vld    <= 1'b0;
      r_error         <= 1'b0;
      r_err_code      <= ERR_NONE;
      r_err_stage     <= '0;
    end else begin
      // Pulse outputs default low every cycle.
      r_stage_start   <= '0;
      r_stage_abort   <= 1'b0;
      r_pipeline_done <= 1'b0;
      r_cycles_vld    <= 1'b0;

      case (r_state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            r_mask      <= stage_enable;
            r_error     <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_err_stage <= '0;
            if (w_first_found) begin
              r_state       <= WAIT;
              r_busy        <= 1'b1;
              r_stage_start <= NUM_STAGES'(1) << w_first_idx;
              r_cur         <= w_first_idx;
              r_cnt         <= CNT_WIDTH'(1);
            end else begin
              // Empty mask: report completion immediately without ever going busy.
              r_state         <= DONE;
              r_pipeline_done <= 1'b1;
            end
          end
        end

        WAIT: begin
          // Abort beats done, done beats timeout.
          if (abort || (!stage_done[r_cur] && (r_cnt == TIMEOUT_VAL))) begin
            r_state       <= ERROR;
            r_busy        <= 1'b0;
            r_stage_abort <= 1'b1;
            r_error       <= 1'b1;
            r_err_code    <= abort ? ERR_ABORT : ERR_TIMEOUT;
            r_err_stage   <= r_cur;
          end else if (stage_done[r_cur]) begin
            r_stage_cycles <= r_cnt;
            r_cycles_vld   <= 1'b1;
            if (w_next_found) begin
              r_stage_start <= NUM_STAGES'(1) << w_next_idx;
              r_cur         <= w_next_idx;
              r_cnt         <= CNT_WIDTH'(1);
            end else begin
              r_state         <= DONE;
              r_busy          <= 1'b0;
              r_pipeline_done <= 1'b1;
            end
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign stage_start        = r_stage_start;
  assign stage_abort        = r_stage_abort;
  assign current_stage      = r_cur;
  assign busy               = r_busy;
  assign pipeline_done      = r_pipeline_done;
  assign stage_cycles       = r_stage_cycles;
  assign stage_cycles_valid = r_cycles_vld;
  assign error              = r_error;
  assign error_code         = r_err_code;
  assign error_stage        = r_err_stage;

endmodule

// File: tb/tb_sift_stage_sequencer.sv
// Directed bench for sift_stage_sequencer with a 16-cycle watchdog.
// Latency: n/a.
// Backpressure: n/a.
module tb_sift_stage_sequencer;

  localparam int NS  = 5;
  localparam int TO  = 16;
  localparam int CW  = 24;
  localparam int IW  = $clog2(NS);

  logic          clk;
  logic          rst_in;
  logic          start;
  logic          abort;
  logic [NS-1:0] stage_enable;
  logic [NS-1:0] stage_done;
  logic [NS-1:0] stage_start;
  logic          stage_abort;
  logic [IW-1:0] current_stage;
  logic          busy;
  logic          pipeline_done;
  logic [CW-1:0] stage_cycles;
  logic          stage_cycles_valid;
  logic          error;
  logic [1:0]    error_code;
  logic [IW-1:0] error_stage;

  int vectors;
  int miscompares;
  int busy_cnt;

  sift_stage_sequencer #(
    .NUM_STAGES     (NS),
    .TIMEOUT_CYCLES (TO),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk                (clk),
    .rst_in             (rst_in),
    .start              (start),
    .abort              (abort),
    .stage_enable       (stage_enable),
    .stage_done         (stage_done),
    .stage_start        (stage_start),
    .stage_abort        (stage_abort),
    .current_stage      (current_stage),
    .busy               (busy),
    .pipeline_done      (pipeline_done),
    .stage_cycles       (stage_cycles),
    .stage_cycles_valid (stage_cycles_valid),
    .error              (error),
    .error_code         (error_code),
    .error_stage        (error_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (busy === 1'b1) busy_cnt++;
  endtask

  // Called in the cycle stage k's start pulse is visible; done arrives so the count equals lat.
  task automatic do_stage(input int k, input int lat);
    for (int i = 1; i < lat; i++) tick();
    stage_done = NS'(1) << k;
    tick();
    stage_done = '0;
    chk($sformatf("cyc_vld_s%0d", k), 32'(stage_cycles_valid), 1);
    chk($sformatf("cycles_s%0d", k), 32'(stage_cycles), 32'(lat));
  endtask

  task automatic pulse_start(input logic [NS-1:0] mask);
    stage_enable = mask;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    busy_cnt     = 0;
    rst_in       = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    stage_enable = '0;
    stage_done   = '0;

    // ---- reset state ----
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(stage_start), 0);
    chk("rst_pdone", 32'(pipeline_done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_cur", 32'(current_stage), 0);
    rst_in = 1'b0;
    tick();

    // ---- 1: full run, 4-cycle stages ----
    busy_cnt = 0;
    pulse_start(5'b11111);
    for (int k = 0; k < NS; k++) begin
      chk($sformatf("full_start%0d", k), 32'(stage_start), 32'(1 << k));
      chk($sformatf("full_cur%0d", k), 32'(current_stage), 32'(k));
      do_stage(k, 4);
    end
    chk("full_pdone", 32'(pipeline_done), 1);
    chk("full_busy_end", 32'(busy), 0);
    chk("full_start_end", 32'(stage_start), 0);
    tick();
    chk("full_busy_cycles", 32'(busy_cnt), 20);
    chk("full_pdone_pulse", 32'(pipeline_done), 0);

    // ---- 2: skip mask 10101, then empty mask ----
    pulse_start(5'b10101);
    chk("skip_start0", 32'(stage_start), 32'h01);
    chk("skip_cur0", 32'(current_stage), 0);
    do_stage(0, 2);
    chk("skip_start2", 32'(stage_start), 32'h04);
    chk("skip_cur2", 32'(current_stage), 2);
    do_stage(2, 2);
    chk("skip_start4", 32'(stage_start), 32'h10);
    chk("skip_cur4", 32'(current_stage), 4);
    do_stage(4, 2);
    chk("skip_pdone", 32'(pipeline_done), 1);
    chk("skip_cur_hold", 32'(current_stage), 4);
    tick();
    busy_cnt = 0;
    pulse_start(5'b00000);
    chk("empty_pdone", 32'(pipeline_done), 1);
    chk("empty_busy", 32'(busy), 0);
    chk("empty_start", 32'(stage_start), 0);
    tick();
    chk("empty_busy_cycles", 32'(busy_cnt), 0);

    // ---- 3: timeout on stage 2 ----
    pulse_start(5'b11111);
    do_stage(0, 2);
    do_stage(1, 2);
    chk("to_start2", 32'(stage_start), 32'h04);
    for (int i = 0; i < TO - 1; i++) tick();
    chk("to_not_yet", 32'(stage_abort), 0);
    chk("to_busy_before", 32'(busy), 1);
    tick();
    chk("to_abort", 32'(stage_abort), 1);
    chk("to_error", 32'(error), 1);
    chk("to_code", 32'(error_code), 1);
    chk("to_stage", 32'(error_stage), 2);
    chk("to_busy", 32'(busy), 0);
    chk("to_no_cycvld", 32'(stage_cycles_valid), 0);
    tick();
    chk("to_abort_pulse", 32'(stage_abort), 0);
    chk("to_error_sticky", 32'(error), 1);

    // ---- restart clears error; 5: spurious inputs and done at count 16 ----
    pulse_start(5'b11111);
    chk("rs_error_clr", 32'(error), 0);
    chk("rs_code_clr", 32'(error_code), 0);
    chk("rs_start0", 32'(stage_start), 32'h01);
    chk("rs_cur0", 32'(current_stage), 0);
    do_stage(0, 2);
    stage_done   = 5'b10000;
    start        = 1'b1;
    stage_enable = 5'b00001;
    tick();
    stage_done = '0;
    start      = 1'b0;
    chk("spur_no_cycvld", 32'(stage_cycles_valid), 0);
    chk("spur_no_start", 32'(stage_start), 0);
    chk("spur_cur", 32'(current_stage), 1);
    chk("spur_busy", 32'(busy), 1);
    for (int i = 0; i < 14; i++) tick();
    stage_done = 5'b00010;
    tick();
    stage_done = '0;
    chk("edge_cycvld", 32'(stage_cycles_valid), 1);
    chk("edge_cycles", 32'(stage_cycles), 16);
    chk("edge_no_abort", 32'(stage_abort), 0);
    chk("edge_start2", 32'(stage_start), 32'h04);

    // ---- 4: abort coincident with done in stage 3 ----
    do_stage(2, 2);
    chk("ab_start3", 32'(stage_start), 32'h08);
    tick();
    abort      = 1'b1;
    stage_done = 5'b01000;
    tick();
    abort      = 1'b0;
    stage_done = '0;
    chk("ab_abort", 32'(stage_abort), 1);
    chk("ab_code", 32'(error_code), 2);
    chk("ab_stage", 32'(error_stage), 3);
    chk("ab_no_cycvld", 32'(stage_cycles_valid), 0);
    chk("ab_no_start4", 32'(stage_start), 0);
    chk("ab_busy", 32'(busy), 0);
    tick();
    chk("ab_no_start4_later", 32'(stage_start), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_idle_ignored", 32'(stage_abort), 0);
    chk("ab_code_hold", 32'(error_code), 2);

    // ---- 6: asynchronous reset during stage 2 ----
    pulse_start(5'b11111);
    do_stage(0, 2);
    do_stage(1, 2);
    tick();
    #2;
    rst_in = 1'b1;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_cur", 32'(current_stage), 0);
    chk("ar_cycles", 32'(stage_cycles), 0);
    chk("ar_start", 32'(stage_start), 0);
    chk("ar_abort", 32'(stage_abort), 0);
    chk("ar_error", 32'(error), 0);
    #2;
    rst_in = 1'b0;
    tick();
    chk("ar_post_abort", 32'(stage_abort), 0);
    chk("ar_post_busy", 32'(busy), 0);
    pulse_start(5'b11111);
    chk("ar_rs_start0", 32'(stage_start), 32'h01);
    chk("ar_rs_cur0", 32'(current_stage), 0);
    do_stage(0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
